// File: rtl/sram_controller.sv
// Cache-side bridge to a 16-bit asynchronous SRAM: 64-bit pair reads, 32-bit writes.
// Optional SRAM_STAT_EN adds saturating read/write completion counters.
module sram_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        write_en,
  input  logic        read_en,
  output logic [63:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
`ifdef SRAM_STAT_EN
  ,
  output logic [15:0] read_count,
  output logic [15:0] write_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cyc_q;
  logic [1:0]  half_q;
  logic [16:0] wb_q;
  logic [31:0] wdata_q;
  logic [16:0] wb_in;
  logic        last;
  logic        busy;

  assign wb_in = 17'((address - BASE) >> 2);
  assign last  = (cyc_q == LAST);
  assign busy  = (state == READ) || (state == WRITE);

  // Ready is forced high during reset so the cache never stalls on it.
  assign ready = (state == DONE) ||
                 ((state == IDLE) && (rst || !(read_en || write_en)));

  assign SRAM_DQ = (state == WRITE) ?
                   (half_q[0] ? wdata_q[31:16] : wdata_q[15:0]) :
                   16'hzzzz;

  always_comb begin
    SRAM_CE_N = !busy;
    SRAM_UB_N = !busy;
    SRAM_LB_N = !busy;
    SRAM_OE_N = (state != READ);
    SRAM_WE_N = (state != WRITE);
    SRAM_ADDR = '0;
    if (state == READ)
      SRAM_ADDR = {wb_q ^ {16'b0, half_q[1]}, half_q[0]};
    else if (state == WRITE)
      SRAM_ADDR = {wb_q, half_q[0]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (write_en)
          state_nxt = WRITE;
        else if (read_en)
          state_nxt = READ;
      end
      READ: begin
        if (last && half_q == 2'd3)
          state_nxt = DONE;
      end
      WRITE: begin
        if (last && half_q == 2'd1)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      half_q  <= '0;
      wb_q    <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE) begin
        cyc_q  <= '0;
        half_q <= '0;
        if (write_en || read_en)
          wb_q <= wb_in;
        if (write_en)
          wdata_q <= wdata;
      end else if (busy) begin
        if (last) begin
          cyc_q  <= '0;
          half_q <= half_q + 2'd1;
        end else begin
          cyc_q <= cyc_q + 4'd1;
        end
        // Bus is sampled on the final cycle of each halfword slot.
        if (state == READ && last) begin
          unique case (half_q)
            2'd0: rdata[47:32] <= SRAM_DQ;
            2'd1: rdata[63:48] <= SRAM_DQ;
            2'd2: rdata[15:0]  <= SRAM_DQ;
            2'd3: rdata[31:16] <= SRAM_DQ;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef SRAM_STAT_EN
  logic is_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (state == IDLE)
        is_wr_q <= write_en;
      if (state == DONE) begin
        if (is_wr_q && write_count != 16'hFFFF)
          write_count <= write_count + 16'd1;
        if (!is_wr_q && read_count != 16'hFFFF)
          read_count <= read_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM and a
// word-level reference memory.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        write_en;
  logic        read_en;
  logic [63:0] rdata;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
`ifdef SRAM_STAT_EN
  logic [15:0] read_count;
  logic [15:0] write_count;
`endif

  sram_controller dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .wdata     (wdata),
    .write_en  (write_en),
    .read_en   (read_en),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
`ifdef SRAM_STAT_EN
    ,
    .read_count  (read_count),
    .write_count (write_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: halfword image, drives bus while output-enabled.
  logic [15:0] mem [0:262143];
  logic [15:0] mem_rd;
  always_comb mem_rd = mem[SRAM_ADDR];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ?
                   mem_rd : 16'hzzzz;
  always @(posedge clk)
    if (!SRAM_CE_N && !SRAM_WE_N)
      mem[SRAM_ADDR] <= SRAM_DQ;

  // Reference: word-indexed image of what the SRAM should hold.
  logic [31:0] ref_w [0:131071];

  int pass_cnt;
  int total_cnt;

  int          lat;
  int          we_cyc;
  bit          oe_seen;
  bit          got;
  logic [63:0] rd_o;
  logic [17:0] aseq [$];

  function automatic logic [16:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  task automatic preload(input int i, input logic [31:0] v);
    ref_w[i] = v;
    mem[2*i] = v[15:0];
    mem[2*i+1] = v[31:16];
  endtask

  task automatic run_access(input bit wr, input bit rd,
                            input logic [31:0] a, input logic [31:0] d);
    logic [17:0] last_a;
    bit have;
    @(negedge clk);
    address = a;
    wdata = d;
    write_en = wr;
    read_en = rd;
    #1;
    total_cnt++;
    if (ready !== 1'b0)
      $display("FAIL req_ready: got %b want 0", ready);
    else
      pass_cnt++;
    lat = 0; we_cyc = 0; oe_seen = 0; got = 0; have = 0;
    last_a = '0;
    aseq.delete();
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (!SRAM_WE_N) we_cyc++;
      if (!SRAM_OE_N) begin
        oe_seen = 1;
        if (!have || SRAM_ADDR != last_a) begin
          aseq.push_back(SRAM_ADDR);
          last_a = SRAM_ADDR;
          have = 1;
        end
      end
      if (ready) begin
        lat = n;
        rd_o = rdata;
        got = 1;
        break;
      end
    end
    write_en = 0;
    read_en = 0;
    total_cnt++;
    if (!got)
      $display("FAIL timeout: no ready within 64 cycles");
    else
      pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1; read_en = 1; write_en = 0;
    address = 32'h400; wdata = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", ready);
    else pass_cnt++;
    total_cnt++;
    if ({SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 5'b11111)
      $display("FAIL reset_strobes: got %b want 11111",
               {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N});
    else pass_cnt++;
    total_cnt++;
    if (rdata !== 64'h0)
      $display("FAIL reset_rdata: got %h want 0", rdata);
    else pass_cnt++;
    total_cnt++;
    if (SRAM_ADDR !== 18'h0)
      $display("FAIL reset_addr: got %h want 0", SRAM_ADDR);
    else pass_cnt++;
    rst = 0; read_en = 0;
  endtask

  task automatic test_write;
    run_access(1, 0, 32'h400, 32'h11223344);
    ref_w[0] = 32'h11223344;
    total_cnt++;
    if ({mem[1], mem[0]} !== 32'h11223344)
      $display("FAIL write_mem: got %h want 11223344", {mem[1], mem[0]});
    else pass_cnt++;
    total_cnt++;
    if (we_cyc !== 4)
      $display("FAIL write_we_cycles: got %0d want 4", we_cyc);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 5)
      $display("FAIL write_latency: got %0d want 5", lat);
    else pass_cnt++;
  endtask

  task automatic test_read_pair;
    logic [71:0] obs;
    preload(0, 32'h11223344);
    preload(1, 32'h66558877);
    run_access(0, 1, 32'h404, 32'h0);
    obs = (aseq.size() == 4) ?
          {aseq[0], aseq[1], aseq[2], aseq[3]} : '1;
    total_cnt++;
    if (obs !== {18'd2, 18'd3, 18'd0, 18'd1})
      $display("FAIL read_addr_seq: got %h (n=%0d) want 2,3,0,1", obs, aseq.size());
    else pass_cnt++;
    total_cnt++;
    if (rd_o !== 64'h66558877_11223344)
      $display("FAIL read_404: got %h want 6655887711223344", rd_o);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 9)
      $display("FAIL read_latency: got %0d want 9", lat);
    else pass_cnt++;
    run_access(0, 1, 32'h400, 32'h0);
    total_cnt++;
    if (rd_o !== 64'h11223344_66558877)
      $display("FAIL read_400: got %h want 1122334466558877", rd_o);
    else pass_cnt++;
  endtask

  task automatic test_both_en;
    logic [63:0] prev;
    prev = rdata;
    run_access(1, 1, 32'h408, 32'hCAFEF00D);
    ref_w[2] = 32'hCAFEF00D;
    total_cnt++;
    if ({mem[5], mem[4]} !== 32'hCAFEF00D)
      $display("FAIL both_mem: got %h want cafef00d", {mem[5], mem[4]});
    else pass_cnt++;
    total_cnt++;
    if (oe_seen !== 1'b0)
      $display("FAIL both_oe: got oe_seen=%b want 0", oe_seen);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== prev)
      $display("FAIL both_rdata_kept: got %h want %h", rdata, prev);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_write;
    preload(0, 32'hBEEF1234);
    @(negedge clk);
    address = 32'h400; wdata = 32'hAAAA5555; write_en = 1;
    repeat (3) @(negedge clk);
    rst = 1; write_en = 0;
    #1;
    total_cnt++;
    if ({SRAM_WE_N, SRAM_CE_N, SRAM_OE_N} !== 3'b111)
      $display("FAIL abort_strobes: got %b want 111",
               {SRAM_WE_N, SRAM_CE_N, SRAM_OE_N});
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    ref_w[0] = {ref_w[0][31:16], 16'h5555};
    total_cnt++;
    if (mem[1] !== 16'hBEEF)
      $display("FAIL abort_high_half: got %h want beef", mem[1]);
    else pass_cnt++;
    run_access(0, 1, 32'h400, 32'h0);
    total_cnt++;
    if (rd_o !== {ref_w[0], ref_w[1]} || lat !== 9)
      $display("FAIL abort_next_read: got %h lat %0d want %h lat 9",
               rd_o, lat, {ref_w[0], ref_w[1]});
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic [16:0] wi;
    logic [63:0] prev, exp;
    bit wr, rd;
    for (int it = 0; it < 24; it++) begin
      a = 32'h400 + 32'($urandom_range(0, 7) * 4) +
          32'($urandom_range(0, 3)) + (32'($urandom_range(0, 3)) << 19);
      d = $urandom;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      wi = word_idx(a);
      prev = rdata;
      run_access(wr, rd, a, d);
      if (wr) begin
        ref_w[wi] = d;
        total_cnt++;
        if ({mem[{wi, 1'b1}], mem[{wi, 1'b0}]} !== d || lat !== 5 ||
            rdata !== prev)
          $display("FAIL rand_write %0d: a=%h mem=%h lat=%0d rdata=%h want %h lat 5 rdata %h",
                   it, a, {mem[{wi, 1'b1}], mem[{wi, 1'b0}]}, lat, rdata, d, prev);
        else pass_cnt++;
      end else begin
        exp = {ref_w[wi], ref_w[wi ^ 17'd1]};
        total_cnt++;
        if (rd_o !== exp || lat !== 9)
          $display("FAIL rand_read %0d: a=%h got %h lat %0d want %h lat 9",
                   it, a, rd_o, lat, exp);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    for (int i = 0; i < 131072; i++) ref_w[i] = '0;
    test_reset();
    test_write();
    test_read_pair();
    test_both_en();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
